mips_ctrl_fsm: RTL and testbench

Multicycle main controller for the MIPS datapath: the producer of the ALU `sel` code and the consumer of the ALU zero flag. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath enable and mux select, resolves branches from `alu_zero_flag`, and counts retired instructions.

---
 rtl/mips_ctrl_fsm_pkg.sv | 64 ++++++
 rtl/mips_ctrl_fsm_alu_op_decode.sv | 23 ++
 rtl/mips_ctrl_fsm.sv | 169 ++++++++++++++++
 tb/tb_mips_ctrl_fsm.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_fsm_pkg.sv
// Shared constants and types for the multicycle MIPS main controller:
// widths, ALU codes, opcode/funct values, state encoding and the control bundle.
package mips_ctrl_fsm_pkg;

  localparam int WORD_SIZE = 32;
  localparam int OP_SIZE   = 3;

  localparam logic [OP_SIZE-1:0] ALU_AND = 3'b000;
  localparam logic [OP_SIZE-1:0] ALU_OR  = 3'b001;
  localparam logic [OP_SIZE-1:0] ALU_ADD = 3'b010;
  localparam logic [OP_SIZE-1:0] ALU_SUB = 3'b110;
  localparam logic [OP_SIZE-1:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEX    = 4'd10,
    S_IWB    = 4'd11
  } state_e;

  typedef struct packed {
    logic               pc_write;
    logic               branch;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_source;
    logic [OP_SIZE-1:0] alu_sel;
    logic               instr_done;
  } ctrl_t;

  function automatic logic opcode_known(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_ctrl_fsm_alu_op_decode.sv
// R-type funct to ALU select; unsupported functs report legal_o = 0 and select ADD.
module alu_op_decode
  import mips_ctrl_fsm_pkg::*;
(
  input  logic [5:0]         funct_i,
  output logic [OP_SIZE-1:0] alu_sel_o,
  output logic               legal_o
);

  always_comb begin
    alu_sel_o = ALU_ADD;
    legal_o   = 1'b1;
    case (funct_i)
      FN_ADD:  alu_sel_o = ALU_ADD;
      FN_SUB:  alu_sel_o = ALU_SUB;
      FN_AND:  alu_sel_o = ALU_AND;
      FN_OR:   alu_sel_o = ALU_OR;
      FN_SLT:  alu_sel_o = ALU_SLT;
      default: legal_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS main controller: Moore FSM driving datapath enables/selects,
// resolving beq from the ALU zero flag and counting retired instructions.
module mips_ctrl_fsm
  import mips_ctrl_fsm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 alu_zero_flag,
  output logic                 pc_en,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_source,
  output logic [OP_SIZE-1:0]   alu_sel,
  output logic                 illegal_op,
  output logic                 instr_done,
  output logic [WORD_SIZE-1:0] instr_count,
  output logic [3:0]           dbg_state
);

  state_e               state_q, state_d;
  logic                 is_lw_q;
  logic [WORD_SIZE-1:0] instr_count_q;
  logic [OP_SIZE-1:0]   fn_alu_sel;
  logic                 fn_legal;
  logic                 decode_illegal;
  ctrl_t                ctrl;
  logic                 illegal_q_unused;

  alu_op_decode u_alu_op_decode (
    .funct_i   (funct),
    .alu_sel_o (fn_alu_sel),
    .legal_o   (fn_legal)
  );

  assign decode_illegal = !opcode_known(opcode) || ((opcode == OP_RTYPE) && !fn_legal);

  // lw/sw choice is captured in DECODE so opcode is not looked at again in MEMADR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      is_lw_q       <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) is_lw_q <= (opcode == OP_LW);
      if (ctrl.instr_done) instr_count_q <= instr_count_q + WORD_SIZE'(1);
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (decode_illegal) state_d = S_FETCH;
        else begin
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_REX;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
            OP_ADDI:      state_d = S_IEX;
            default:      state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: state_d = is_lw_q ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_REX:    state_d = S_RWB;
      S_IEX:    state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Reset overrides every Moore output; alu_sel idles at ADD.
  always_comb begin
    ctrl             = '0;
    ctrl.alu_sel     = ALU_ADD;
    illegal_q_unused = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
      end
      S_DECODE: begin
        ctrl.alu_src_b   = 2'b11;
        illegal_q_unused = decode_illegal;
      end
      S_MEMADR, S_IEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_REX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_sel   = fn_alu_sel;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_sel    = ALU_SUB;
        ctrl.branch     = 1'b1;
        ctrl.pc_source  = 2'b01;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = 2'b10;
        ctrl.instr_done = 1'b1;
      end
      S_IWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      ctrl             = '0;
      ctrl.alu_sel     = ALU_ADD;
      illegal_q_unused = 1'b0;
    end
  end

  assign pc_en       = ctrl.pc_write | (ctrl.branch & alu_zero_flag);
  assign iord        = ctrl.iord;
  assign mem_read    = ctrl.mem_read;
  assign mem_write   = ctrl.mem_write;
  assign ir_write    = ctrl.ir_write;
  assign reg_write   = ctrl.reg_write;
  assign reg_dst     = ctrl.reg_dst;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign pc_source   = ctrl.pc_source;
  assign alu_sel     = ctrl.alu_sel;
  assign illegal_op  = illegal_q_unused;
  assign instr_done  = ctrl.instr_done;
  assign instr_count = rst ? '0 : instr_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Randomized bench for mips_ctrl_fsm: each instruction is expanded into its
// expected state walk and per-cycle control outputs from the controller's rules.
module tb_mips_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        alu_zero_flag;
  logic        pc_en, iord, mem_read, mem_write, ir_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a, illegal_op, instr_done;
  logic [1:0]  alu_src_b, pc_source;
  logic [2:0]  alu_sel;
  logic [31:0] instr_count;
  logic [3:0]  dbg_state;
  logic [17:0] obs;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_count;
  logic [3:0]  exp_q[$];

  localparam logic [17:0] RESET_VEC = {13'b0, 3'b010, 2'b00};

  always #5 clk = ~clk;

  mips_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero_flag(alu_zero_flag), .pc_en(pc_en), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_sel(alu_sel), .illegal_op(illegal_op), .instr_done(instr_done),
    .instr_count(instr_count), .dbg_state(dbg_state)
  );

  assign obs = {pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_sel,
                illegal_op, instr_done};

  function automatic logic [2:0] alu_of(logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic bit is_legal(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'h23, 6'h2B, 6'h04, 6'h02, 6'h08: return 1'b1;
      6'h00: return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
      default: return 1'b0;
    endcase
  endfunction

  // Expected output bundle for one cycle, from the controller's output table.
  function automatic logic [17:0] exp_out(int s, logic [5:0] fn, logic z, bit ill);
    logic pe, io, mr, mw, iw, rw, rd, m2r, sa, il, dn;
    logic [1:0] sb, ps;
    logic [2:0] as;
    {pe, io, mr, mw, iw, rw, rd, m2r, sa, il, dn} = '0;
    sb = 2'b00; ps = 2'b00; as = 3'b010;
    case (s)
      0:  begin mr = 1; iw = 1; pe = 1; sb = 2'b01; end
      1:  begin sb = 2'b11; il = ill; end
      2, 10: begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mw = 1; io = 1; dn = 1; end
      6:  begin sa = 1; as = alu_of(fn); end
      7:  begin rw = 1; rd = 1; dn = 1; end
      8:  begin sa = 1; as = 3'b110; pe = z; ps = 2'b01; dn = 1; end
      9:  begin pe = 1; ps = 2'b10; dn = 1; end
      11: begin rw = 1; dn = 1; end
      default: ;
    endcase
    return {pe, io, mr, mw, iw, rw, rd, m2r, sa, sb, ps, as, il, dn};
  endfunction

  task automatic build_path(input logic [5:0] op, input logic [5:0] fn);
    exp_q.delete();
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    if (is_legal(op, fn)) begin
      case (op)
        6'h23: begin exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4); end
        6'h2B: begin exp_q.push_back(4'd2); exp_q.push_back(4'd5); end
        6'h00: begin exp_q.push_back(4'd6); exp_q.push_back(4'd7); end
        6'h04: exp_q.push_back(4'd8);
        6'h02: exp_q.push_back(4'd9);
        default: begin exp_q.push_back(4'd10); exp_q.push_back(4'd11); end
      endcase
    end
  endtask

  // Runs one instruction from FETCH; abort_at >= 0 asserts rst in that cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int abort_at);
    logic [17:0] exp_v;
    logic [3:0]  s;
    int          n;
    bit          legal;
    legal = is_legal(op, fn);
    build_path(op, fn);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      s = exp_q.pop_front();
      opcode        = (s == 4'd1) ? op : 6'($urandom);
      funct         = (s == 4'd1 || s == 4'd6) ? fn : 6'($urandom);
      alu_zero_flag = (s == 4'd8) ? z : 1'($urandom);
      if (i == abort_at) rst = 1'b1;
      @(negedge clk);
      exp_v = (i == abort_at) ? RESET_VEC : exp_out(int'(s), fn, alu_zero_flag, !legal);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL outputs op=%h fn=%h cyc=%0d got=%h exp=%h", op, fn, i, obs, exp_v);
      end
      if (i == abort_at) begin
        checks++;
        if (instr_count !== 32'd0) begin
          errors++;
          $display("FAIL count_in_reset got=%h exp=0", instr_count);
        end
      end else begin
        checks++;
        if (dbg_state !== s) begin
          errors++;
          $display("FAIL state op=%h fn=%h cyc=%0d got=%0d exp=%0d", op, fn, i, dbg_state, s);
        end
      end
      @(posedge clk); #1;
      if (i == abort_at) begin
        rst = 1'b0;
        exp_count = 32'd0;
        break;
      end
    end
    if (legal && abort_at < 0) exp_count = exp_count + 32'd1;
    checks++;
    if (instr_count !== exp_count) begin
      errors++;
      $display("FAIL count op=%h fn=%h got=%h exp=%h", op, fn, instr_count, exp_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exp_count = 32'd0;
    for (int i = 0; i < 3; i++) begin
      opcode = 6'($urandom); funct = 6'($urandom); alu_zero_flag = 1'($urandom);
      @(negedge clk);
      checks++;
      if (obs !== RESET_VEC || instr_count !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs got=%h cnt=%h exp=%h cnt=0", obs, instr_count, RESET_VEC);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    checks++;
    if (obs !== exp_out(0, 6'h00, 1'b0, 1'b0) || dbg_state !== 4'd0) begin
      errors++;
      $display("FAIL release_fetch got=%h st=%0d exp=%h st=0", obs, dbg_state, exp_out(0, 6'h00, 1'b0, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    run_instr(6'h23, 6'($urandom), 1'b0, 3);
    checks++;
    if (dbg_state !== 4'd0 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fetch got st=%0d rw=%b exp st=0 rw=0", dbg_state, reg_write);
    end
    run_instr(6'h02, 6'($urandom), 1'b0, 2);
  endtask

  task automatic test_lw();
    run_instr(6'h23, 6'($urandom), 1'b0, -1);
  endtask

  task automatic test_beq();
    run_instr(6'h04, 6'($urandom), 1'b1, -1);
    run_instr(6'h04, 6'($urandom), 1'b0, -1);
  endtask

  task automatic test_rtype();
    run_instr(6'h00, 6'h2A, 1'b0, -1);
    run_instr(6'h00, 6'h3F, 1'b0, -1);
    run_instr(6'h3F, 6'h20, 1'b0, -1);
    run_instr(6'h2B, 6'($urandom), 1'b0, -1);
    run_instr(6'h08, 6'($urandom), 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    logic [5:0] op, fn;
    logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0] ops[6] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08};
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3, 4: begin op = ops[$urandom_range(0, 5)]; fn = fns[$urandom_range(0, 4)]; end
        5: begin op = 6'h00; fn = 6'($urandom); end
        6: begin op = 6'($urandom); fn = 6'($urandom); end
        default: begin op = 6'h3E; fn = 6'h20; end
      endcase
      run_instr(op, fn, 1'($urandom), -1);
    end
  endtask

  task automatic test_wrap();
    opcode = 6'($urandom); funct = 6'($urandom);
    @(negedge clk); @(posedge clk); #1;
    opcode = 6'h02;
    @(negedge clk); @(posedge clk); #1;
    opcode = 6'($urandom);
    @(negedge clk);
    checks++;
    if (dbg_state !== 4'd9 || instr_done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_jump got st=%0d done=%b exp st=9 done=1", dbg_state, instr_done);
    end
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    @(posedge clk); #1;
    exp_count = 32'd0;
    checks++;
    if (instr_count !== exp_count || dbg_state !== 4'd0) begin
      errors++;
      $display("FAIL wrap got cnt=%h st=%0d exp cnt=%h st=0", instr_count, dbg_state, exp_count);
    end
  endtask

  initial begin
    rst = 1'b1; opcode = '0; funct = '0; alu_zero_flag = 1'b0;
    exp_count = 32'd0;
    @(posedge clk); #1;
    test_reset();
    test_reset_mid();
    test_lw();
    test_beq();
    test_rtype();
    test_back_to_back();
    test_wrap();
    run_instr(6'h23, 6'h00, 1'b0, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
